// File: rtl/multiplexed_display_controller.sv
// Time-multiplexed common-anode 7-segment driver with a built-in prescaler,
// frame-synchronous data latching, per-digit decimal points, leading-zero
// blanking, PWM brightness and selectable output polarity.
module multiplexed_display_controller #(
  parameter int number_of_nybbles  = 4,
  parameter int prescaler_log2     = 10,
  parameter int brightness_bits    = 4,
  parameter bit anode_active_high  = 1'b1,
  parameter bit cathode_active_low = 1'b1,
  localparam int digit_index_width = (number_of_nybbles > 1) ? $clog2(number_of_nybbles) : 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [4*number_of_nybbles-1:0] data,
  input  logic [number_of_nybbles-1:0]   dp,
  input  logic                           enable,
  input  logic                           blank_leading_zeros,
  input  logic [brightness_bits-1:0]     brightness,
  output logic [7:0]                     cathode,
  output logic [number_of_nybbles-1:0]   anode,
  output logic                           frame_strobe,
  output logic [digit_index_width-1:0]   digit_index
);

  localparam int N = number_of_nybbles;
  localparam int W = digit_index_width;
  localparam int P = prescaler_log2;
  localparam int B = brightness_bits;

  // Inactive levels of the pins, used both at reset and when a slot is dark.
  localparam logic [N-1:0] ANODE_OFF   = anode_active_high ? '0 : '1;
  localparam logic [7:0]   CATHODE_OFF = cathode_active_low ? 8'hFF : 8'h00;

  logic [P-1:0]   slot_cnt, slot_cnt_next;
  logic [W-1:0]   digit_idx, digit_idx_next;
  logic [4*N-1:0] shadow_data, shadow_data_next;
  logic [N-1:0]   shadow_dp, shadow_dp_next;
  logic           shadow_blz, shadow_blz_next;
  logic           primed;
  logic           boundary;

  logic [3:0]     cur_nyb;
  logic           cur_dp;
  logic           cur_zero_run;
  logic           zero_run;
  logic           blank;
  logic           lit;
  logic [6:0]     seg;
  logic [N-1:0]   anode_next;
  logic [7:0]     cathode_next;

  // Hex font in gfedcba order, bit 0 = segment a, 1 = segment lit.
  function automatic logic [6:0] font(input logic [3:0] nyb);
    case (nyb)
      4'h0: font = 7'h3F;
      4'h1: font = 7'h06;
      4'h2: font = 7'h5B;
      4'h3: font = 7'h4F;
      4'h4: font = 7'h66;
      4'h5: font = 7'h6D;
      4'h6: font = 7'h7D;
      4'h7: font = 7'h07;
      4'h8: font = 7'h7F;
      4'h9: font = 7'h6F;
      4'hA: font = 7'h77;
      4'hB: font = 7'h7C;
      4'hC: font = 7'h39;
      4'hD: font = 7'h5E;
      4'hE: font = 7'h79;
      default: font = 7'h71;
    endcase
  endfunction

  // Scan sequencing and frame boundary detection; the shadow copy is only
  // refreshed at a boundary so a frame never mixes old and new data.
  always_comb begin
    slot_cnt_next  = slot_cnt + 1'b1;
    digit_idx_next = digit_idx;
    if (&slot_cnt) begin
      if (digit_idx == W'(N - 1)) digit_idx_next = '0;
      else                        digit_idx_next = digit_idx + 1'b1;
    end
    boundary         = !primed || ((&slot_cnt) && (digit_idx == W'(N - 1)));
    shadow_data_next = boundary ? data                : shadow_data;
    shadow_dp_next   = boundary ? dp                  : shadow_dp;
    shadow_blz_next  = boundary ? blank_leading_zeros : shadow_blz;
  end

  // Decode the digit that will be scanned after this edge, from post-edge
  // state, so the registered outputs carry no extra lag.
  always_comb begin
    cur_nyb      = 4'h0;
    cur_dp       = 1'b0;
    cur_zero_run = 1'b0;
    zero_run     = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      zero_run = zero_run && (shadow_data_next[i*4 +: 4] == 4'h0);
      if (digit_idx_next == W'(i)) begin
        cur_nyb      = shadow_data_next[i*4 +: 4];
        cur_dp       = shadow_dp_next[i];
        cur_zero_run = zero_run;
      end
    end
    blank = shadow_blz_next && (digit_idx_next != '0) && cur_zero_run;
    seg   = blank ? 7'h00 : font(cur_nyb);
    lit   = enable && (slot_cnt_next[P-1 -: B] < brightness) && ((seg != 7'h00) || cur_dp);
    anode_next   = '0;
    cathode_next = 8'h00;
    if (lit) begin
      anode_next   = N'(1) << digit_idx_next;
      cathode_next = {cur_dp, seg};
    end
  end

  // Internal scan state and shadow registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_cnt    <= '0;
      digit_idx   <= '0;
      shadow_data <= '0;
      shadow_dp   <= '0;
      shadow_blz  <= 1'b0;
      primed      <= 1'b0;
    end else begin
      slot_cnt    <= slot_cnt_next;
      digit_idx   <= digit_idx_next;
      shadow_data <= shadow_data_next;
      shadow_dp   <= shadow_dp_next;
      shadow_blz  <= shadow_blz_next;
      primed      <= 1'b1;
    end
  end

  // Registered pin drivers; polarity is applied only at this final stage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      anode        <= ANODE_OFF;
      cathode      <= CATHODE_OFF;
      frame_strobe <= 1'b0;
    end else begin
      anode        <= anode_active_high ? anode_next : ~anode_next;
      cathode      <= cathode_active_low ? ~cathode_next : cathode_next;
      frame_strobe <= boundary;
    end
  end

  assign digit_index = digit_idx;

endmodule

// File: tb/tb_multiplexed_display_controller.sv
// Self-checking bench for multiplexed_display_controller (N=4, 16-clock slots,
// 4-bit brightness, default polarity) against an arithmetic reference model.
module tb_multiplexed_display_controller;

  localparam int N = 4;
  localparam int P = 4;
  localparam int B = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [15:0]  data = 16'h0;
  logic [3:0]   dp = 4'h0;
  logic         enable = 1'b0;
  logic         blank_leading_zeros = 1'b0;
  logic [3:0]   brightness = 4'h0;
  logic [7:0]   cathode;
  logic [3:0]   anode;
  logic         frame_strobe;
  logic [1:0]   digit_index;

  int checks = 0;
  int errors = 0;

  // Reference model state: edges since reset release plus the latched frame.
  int           k = 0;
  bit           in_reset = 1'b0;
  logic [15:0]  m_data = 16'h0;
  logic [3:0]   m_dp = 4'h0;
  bit           m_blz = 1'b0;
  bit           m_en = 1'b0;
  int           m_bright = 0;

  logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  multiplexed_display_controller #(
    .number_of_nybbles (N),
    .prescaler_log2    (P),
    .brightness_bits   (B),
    .anode_active_high (1'b1),
    .cathode_active_low(1'b1)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .data               (data),
    .dp                 (dp),
    .enable             (enable),
    .blank_leading_zeros(blank_leading_zeros),
    .brightness         (brightness),
    .cathode            (cathode),
    .anode              (anode),
    .frame_strobe       (frame_strobe),
    .digit_index        (digit_index)
  );

  // Free-running 10-unit clock.
  always #5 clock = ~clock;

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, k);
    end
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic modelEdge();
    if (!in_reset) begin
      k++;
      if (k == 1 || (k % (N * 16)) == 0) begin
        m_data = data;
        m_dp   = dp;
        m_blz  = blank_leading_zeros;
      end
      m_en     = enable;
      m_bright = int'(brightness);
    end
  endtask

  task automatic checkOutput(input string tag);
    int         cnt, dig, nyb;
    bit         blank, dpb, lit, strobe;
    logic [6:0] segs;
    logic [3:0] exp_anode;
    logic [7:0] exp_cath;
    if (in_reset || k == 0) begin
      exp_anode = 4'h0;
      exp_cath  = 8'hFF;
      strobe    = 1'b0;
      dig       = 0;
    end else begin
      cnt    = k % 16;
      dig    = (k / 16) % N;
      strobe = (k == 1) || ((k % (N * 16)) == 0);
      nyb    = int'((m_data >> (4 * dig)) & 16'hF);
      blank  = m_blz && dig > 0 && ((m_data >> (4 * dig)) == 16'h0);
      segs   = blank ? 7'h00 : font[nyb];
      dpb    = m_dp[dig];
      lit    = m_en && ((cnt >> (P - B)) < m_bright) && (segs != 7'h00 || dpb);
      exp_anode = lit ? 4'(1 << dig) : 4'h0;
      exp_cath  = lit ? ~{dpb, segs} : 8'hFF;
    end
    compare({tag, ".anode"}, 32'(anode), 32'(exp_anode));
    compare({tag, ".cathode"}, 32'(cathode), 32'(exp_cath));
    compare({tag, ".strobe"}, 32'(frame_strobe), 32'(strobe));
    compare({tag, ".digit_index"}, 32'(digit_index), 32'(dig));
  endtask

  task automatic applyStimulus(input int cycles, input string tag);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clock);
      modelEdge();
      #1;
      checkOutput(tag);
    end
  endtask

  // Step until the post-edge position within the frame equals target.
  task automatic stepTo(input int target, input string tag);
    int guard;
    guard = 0;
    while ((k % (N * 16)) != target && guard < 200) begin
      applyStimulus(1, tag);
      guard++;
    end
    compare({tag, ".reached"}, 32'(k % (N * 16)), 32'(target));
  endtask

  initial begin
    $display("[TB] start");
    #2;
    reset = 1'b0;
    in_reset = 1'b1;
    #1;
    checkOutput("reset_async");
    applyStimulus(3, "reset_hold");

    data = 16'h1234; dp = 4'h0; brightness = 4'd15; enable = 1'b1; blank_leading_zeros = 1'b0;
    reset = 1'b1; in_reset = 1'b0; k = 0;
    m_data = 16'h0; m_dp = 4'h0; m_blz = 1'b0; m_en = 1'b0; m_bright = 0;
    applyStimulus(70, "digits_1234");
    stepTo(5, "slot0");
    compare("slot0.cathode_4", 32'(cathode), 32'h99);
    compare("slot0.anode", 32'(anode), 32'h1);
    stepTo(53, "slot3");
    compare("slot3.cathode_1", 32'(cathode), 32'hF9);
    compare("slot3.anode", 32'(anode), 32'h8);

    blank_leading_zeros = 1'b1; data = 16'h0042;
    applyStimulus(140, "blz_0042");
    data = 16'h0000;
    applyStimulus(128, "blz_0000");
    dp = 4'b0100;
    applyStimulus(128, "blz_dp2");
    stepTo(37, "blz_dp2_slot2");
    compare("blz_dp2.cathode_dp", 32'(cathode), 32'h7F);

    blank_leading_zeros = 1'b0; dp = 4'h0; data = 16'h1234; brightness = 4'd8;
    applyStimulus(140, "bright8");
    brightness = 4'd0;
    applyStimulus(128, "bright0");

    brightness = 4'd15;
    stepTo(20, "pre_change");
    data = 16'hABCD;
    applyStimulus(140, "change_abcd");

    applyStimulus(7, "pre_disable");
    enable = 1'b0;
    applyStimulus(40, "disabled");
    enable = 1'b1;
    applyStimulus(40, "reenabled");

    for (int r = 0; r < 60; r++) begin
      data = 16'($urandom) >> (4 * $urandom_range(0, 4));
      dp = 4'($urandom);
      blank_leading_zeros = 1'($urandom);
      brightness = 4'($urandom);
      enable = ($urandom % 4) != 0;
      applyStimulus($urandom_range(1, 30), "random");
    end

    reset = 1'b0;
    in_reset = 1'b1;
    #1;
    checkOutput("reset_mid");
    applyStimulus(5, "reset_mid_hold");
    reset = 1'b1; in_reset = 1'b0; k = 0;
    m_data = 16'h0; m_dp = 4'h0; m_blz = 1'b0; m_en = 1'b0; m_bright = 0;
    data = 16'h5A0F; dp = 4'b1001; blank_leading_zeros = 1'b1; brightness = 4'd12; enable = 1'b1;
    applyStimulus(140, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
